// File: rtl/frame_cfg_pkg.sv
// Shared constants, widths and FSM state type for the frame configuration writer.
package frame_cfg_pkg;

   // Fabric geometry
   localparam int unsigned FRAME_BITS_PER_ROW = 32;
   localparam int unsigned MAX_FRAMES_PER_COL = 20;
   localparam int unsigned NUM_ROWS           = 4;
   localparam int unsigned NUM_COLUMNS        = 4;

   // Derived widths
   localparam int unsigned WORD_W       = FRAME_BITS_PER_ROW;
   localparam int unsigned FRAME_DATA_W = NUM_ROWS * FRAME_BITS_PER_ROW;
   localparam int unsigned STROBE_W     = NUM_COLUMNS * MAX_FRAMES_PER_COL;
   localparam int unsigned COL_W        = $clog2(NUM_COLUMNS);
   localparam int unsigned FRM_W        = $clog2(MAX_FRAMES_PER_COL);
   localparam int unsigned ROW_W        = $clog2(NUM_ROWS);
   localparam int unsigned CNT_W        = 16;

   // Stream control words
   localparam logic [WORD_W-1:0] SYNC_WORD  = 32'hFAB0_FAB1;
   localparam logic [7:0]        OP_WRITE   = 8'h01;
   localparam logic [7:0]        OP_DESYNC  = 8'h02;

   // Header field positions (each field is 8 bits wide)
   localparam int unsigned HDR_FIELD_W   = 8;
   localparam int unsigned HDR_OP_LSB    = 24;
   localparam int unsigned HDR_COL_LSB   = 16;
   localparam int unsigned HDR_FRAME_LSB = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2,
      STROBE = 2'd3
   } state_t;

endpackage

// File: rtl/frame_config_writer_if.sv
// Bitstream word stream: valid/ready handshake carrying one 32-bit word per transfer.
//   master : drives s_data, s_valid; receives s_ready
//   slave  : receives s_data, s_valid; drives s_ready
interface frame_config_writer_if;
   import frame_cfg_pkg::*;

   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input  s_ready);
   modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/frame_strobe_decoder.sv
// One-hot decode of (column, frame) into the fabric-wide FrameStrobe vector.
//   column, frame : latched frame address
//   enable        : when low the output is all zero
//   strobe_c      : bit column*MAX_FRAMES_PER_COL+frame set when enabled
module frame_strobe_decoder
   import frame_cfg_pkg::*;
(
   input  logic [COL_W-1:0]    column,
   input  logic [FRM_W-1:0]    frame,
   input  logic                enable,
   output logic [STROBE_W-1:0] strobe_c
);

   always_comb begin
      strobe_c = '0;
      for (int unsigned c = 0; c < NUM_COLUMNS; c++) begin
         for (int unsigned f = 0; f < MAX_FRAMES_PER_COL; f++) begin
            strobe_c[c*MAX_FRAMES_PER_COL + f] = enable &&
                                                 (column == COL_W'(c)) &&
                                                 (frame  == FRM_W'(f));
         end
      end
   end

endmodule

// File: rtl/frame_config_writer.sv
// Frame writer: parses a SYNC/HEADER/DATA word stream, assembles one frame across
// all rows and fires a single-cycle FrameStrobe into the addressed column.
//   CLK, resetn    : clock, asynchronous active-low reset
//   s              : slave side of the bitstream word stream
//   FrameData      : row r on bits [r*32+31:r*32]
//   FrameStrobe    : one-hot strobe, high only for the single STROBE cycle
//   busy           : high outside IDLE
//   err            : sticky protocol error, cleared by reset or SYNC
//   frames_written : strobes issued, wrapping 16-bit count
module frame_config_writer
   import frame_cfg_pkg::*;
(
   input  logic                    CLK,
   input  logic                    resetn,
   frame_config_writer_if.slave    s,
   output logic [FRAME_DATA_W-1:0] FrameData,
   output logic [STROBE_W-1:0]     FrameStrobe,
   output logic                    busy,
   output logic                    err,
   output logic [CNT_W-1:0]        frames_written
);

   state_t                                    state;
   logic [NUM_ROWS-1:0][FRAME_BITS_PER_ROW-1:0] rows_q;
   logic [ROW_W-1:0]                          row_cnt;
   logic [COL_W-1:0]                          col_q;
   logic [FRM_W-1:0]                          frm_q;
   logic                                      skip_q;

   logic                    xfer;
   logic [7:0]              hdr_op;
   logic [7:0]              hdr_col;
   logic [7:0]              hdr_frame;
   logic                    addr_ok;
   logic                    last_row;
   logic [STROBE_W-1:0]     strobe_c;

   assign xfer      = s.s_valid && s.s_ready;
   assign hdr_op    = s.s_data[HDR_OP_LSB    +: HDR_FIELD_W];
   assign hdr_col   = s.s_data[HDR_COL_LSB   +: HDR_FIELD_W];
   assign hdr_frame = s.s_data[HDR_FRAME_LSB +: HDR_FIELD_W];
   assign addr_ok   = (hdr_col < 8'(NUM_COLUMNS)) && (hdr_frame < 8'(MAX_FRAMES_PER_COL));
   assign last_row  = (state == DATA) && xfer && (row_cnt == ROW_W'(NUM_ROWS - 1));
   assign FrameData = rows_q;

   // Decode is enabled on the accepting edge of the last row so the registered strobe
   // lands exactly in the STROBE cycle.
   frame_strobe_decoder u_decoder (
      .column   (col_q),
      .frame    (frm_q),
      .enable   (last_row && !skip_q),
      .strobe_c (strobe_c)
   );

   // Protocol FSM with all outputs registered
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         rows_q         <= '0;
         row_cnt        <= '0;
         col_q          <= '0;
         frm_q          <= '0;
         skip_q         <= 1'b0;
         FrameStrobe    <= '0;
         busy           <= 1'b0;
         err            <= 1'b0;
         frames_written <= '0;
         s.s_ready      <= 1'b0;
      end else begin
         s.s_ready   <= 1'b1;
         FrameStrobe <= strobe_c;
         case (state)
            IDLE: begin
               if (xfer && (s.s_data == SYNC_WORD)) begin
                  err   <= 1'b0;
                  state <= HEADER;
                  busy  <= 1'b1;
               end
            end
            HEADER: begin
               if (xfer) begin
                  if (hdr_op == OP_WRITE) begin
                     // Out-of-range address still consumes the data words, in skip mode
                     col_q   <= COL_W'(hdr_col);
                     frm_q   <= FRM_W'(hdr_frame);
                     skip_q  <= !addr_ok;
                     row_cnt <= '0;
                     state   <= DATA;
                     if (!addr_ok) err <= 1'b1;
                  end else if (hdr_op == OP_DESYNC) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else if (s.s_data != SYNC_WORD) begin
                     err   <= 1'b1;
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  if (!skip_q) rows_q[row_cnt] <= s.s_data;
                  if (row_cnt == ROW_W'(NUM_ROWS - 1)) begin
                     if (skip_q) begin
                        state <= HEADER;
                     end else begin
                        state          <= STROBE;
                        s.s_ready      <= 1'b0;
                        frames_written <= frames_written + CNT_W'(1);
                     end
                  end else begin
                     row_cnt <= row_cnt + ROW_W'(1);
                  end
               end
            end
            STROBE: begin
               state <= HEADER;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
